// File: rtl/snd_dac_out_if.sv
// Sample inputs from the sound sources and the 1-bit DAC pin outputs of snd_dac_out.
// slave = the DAC stage, master = whatever drives the sound sources.
interface snd_dac_out_if;
    logic [15:0] opl_snd;
    logic [15:0] tandy_snd;
    logic        speaker_in;
    logic        mute;
    logic        sample_strobe;
    logic        clip;
    logic        aud_l;
    logic        aud_r;

    modport slave (
        input  opl_snd, tandy_snd, speaker_in, mute,
        output sample_strobe, clip, aud_l, aud_r
    );

    modport master (
        output opl_snd, tandy_snd, speaker_in, mute,
        input  sample_strobe, clip, aud_l, aud_r
    );
endinterface

// File: rtl/snd_dac_out.sv
// Mixes OPL2/Tandy/speaker at 1/SAMPLE_DIV, saturates, volume-ramps, sigma-delta to AUD pins (SND_DITHER_EN adds LFSR dither).
// Latency: pcm_u updates 3 edges after the strobe cycle; modulator adds 2 registered stages to the pins.
// Backpressure: none, inputs are sampled on the strobe and ignored otherwise.
module snd_dac_out #(
    parameter int SAMPLE_DIV  = 648,
    parameter int OPL_SHIFT   = 1,
    parameter int TANDY_SHIFT = 0,
    parameter int SPK_SHIFT   = 13
) (
    input  logic         clock,
    input  logic         reset,
    snd_dac_out_if.slave bus
);
    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0]   cnt;
    logic               strobe;
    logic [1:0]         spk_sync;
    logic [15:0]        opl_h;
    logic [15:0]        tandy_h;
    logic               spk_h;
    logic               s1_vld;
    logic               s2_vld;
    logic signed [23:0] opl_ext;
    logic signed [23:0] tandy_ext;
    logic signed [23:0] spk_ext;
    logic signed [23:0] sum;
    logic signed [15:0] sat;
    logic signed [15:0] sat_q;
    logic               over;
    logic               clip_q;
    logic [8:0]         level;
    logic signed [25:0] prod;
    logic [15:0]        pcm_u;
    logic [15:0]        mod_in;
    logic [16:0]        acc;
    logic               aud_q;
    logic               unused_prod;

    assign strobe = (cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            spk_sync <= 2'b00;
        end else begin
            cnt      <= strobe ? '0 : cnt + 1'b1;
            spk_sync <= {spk_sync[0], bus.speaker_in};
        end
    end

    // Mix in 24 bits so no shifted term can overflow before the clamp.
    always_comb begin
        opl_ext   = {{8{opl_h[15]}}, opl_h} <<< OPL_SHIFT;
        tandy_ext = {{8{tandy_h[15]}}, tandy_h} <<< TANDY_SHIFT;
        spk_ext   = spk_h ? (24'sd1 <<< SPK_SHIFT) : 24'sd0;
        sum       = opl_ext + tandy_ext + spk_ext;
        over      = 1'b1;
        if (sum > 24'sd32767) begin
            sat = 16'sh7FFF;
        end else if (sum < -24'sd32768) begin
            sat = 16'sh8000;
        end else begin
            sat  = sum[15:0];
            over = 1'b0;
        end
    end

    assign prod        = 26'(sat_q) * 26'($signed({1'b0, level}));
    assign unused_prod = ^{prod[25:24], prod[7:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opl_h   <= '0;
            tandy_h <= '0;
            spk_h   <= 1'b0;
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            sat_q   <= '0;
            clip_q  <= 1'b0;
            level   <= '0;
            pcm_u   <= 16'h8000;
        end else begin
            s1_vld <= strobe;
            s2_vld <= s1_vld;
            clip_q <= s1_vld & over;
            if (strobe) begin
                opl_h   <= bus.opl_snd;
                tandy_h <= bus.tandy_snd;
                spk_h   <= spk_sync[1];
                if (bus.mute) begin
                    if (level != 9'd0) level <= level - 1'b1;
                end else begin
                    if (level != 9'd256) level <= level + 1'b1;
                end
            end
            if (s1_vld) sat_q <= sat;
            // Offset binary: flipping the sign bit maps -32768..32767 onto 0..65535.
            if (s2_vld) pcm_u <= {~prod[23], prod[22:8]};
        end
    end

`ifdef SND_DITHER_EN
    logic [15:0] lfsr;
    logic [16:0] dith_sum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign dith_sum = {1'b0, pcm_u} + {15'b0, lfsr[1:0]};
    assign mod_in   = dith_sum[16] ? 16'hFFFF : dith_sum[15:0];
`else
    assign mod_in = pcm_u;
`endif

    // Carry out of the 16-bit accumulator is the density-modulated bitstream.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            aud_q <= 1'b0;
        end else begin
            acc   <= {1'b0, acc[15:0]} + {1'b0, mod_in};
            aud_q <= acc[16];
        end
    end

    assign bus.sample_strobe = strobe;
    assign bus.clip          = clip_q;
    assign bus.aud_l         = aud_q;
    assign bus.aud_r         = aud_q;
endmodule

// File: tb/tb_snd_dac_out.sv
// Directed bench for snd_dac_out with a short sample divider to keep ramps and windows small.
module tb_snd_dac_out;
    localparam int DIV = 16;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   clip_seen = 0;
    int   ones_seen = 0;
    int   ar_diff   = 0;

    snd_dac_out_if bus();

    snd_dac_out #(.SAMPLE_DIV(DIV)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            clip_seen += int'(bus.clip);
            ones_seen += int'(bus.aud_l);
            if (bus.aud_l !== bus.aud_r) ar_diff++;
        end
    endtask

    task automatic wait_strobe();
        int n;
        n = 0;
        step(1);
        while (bus.sample_strobe !== 1'b1 && n < 3 * DIV) begin
            step(1);
            n++;
        end
        if (bus.sample_strobe !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL strobe_timeout observed=0 expected=1");
        end
    endtask

    task automatic wait_strobes(input int n);
        for (int i = 0; i < n; i++) wait_strobe();
    endtask

    initial begin
        logic [7:0] bits;
        int first;
        int c0;
        int o0;
        int n;

        reset          = 1'b1;
        bus.opl_snd    = 16'h0000;
        bus.tandy_snd  = 16'h0000;
        bus.speaker_in = 1'b0;
        bus.mute       = 1'b0;
        step(3);
        chk("rst_strobe", {31'b0, bus.sample_strobe}, 32'd0);
        chk("rst_clip",   {31'b0, bus.clip}, 32'd0);
        chk("rst_aud_l",  {31'b0, bus.aud_l}, 32'd0);
        chk("rst_aud_r",  {31'b0, bus.aud_r}, 32'd0);
        chk("rst_pcm",    {16'b0, dut.pcm_u}, 32'h8000);
        chk("rst_level",  {23'b0, dut.level}, 32'd0);

        // Release: bitstream at mid-scale and first strobe position.
        reset = 1'b0;
        bits  = '0;
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (i <= 8) bits[i-1] = bus.aud_l;
            if (first == 0 && bus.sample_strobe === 1'b1) first = i;
        end
        chk("alt_pattern", {24'b0, bits}, 32'h54);
        chk("first_strobe", first, 32'd15);

        // Full ramp up with silence in.
        c0 = clip_seen;
        wait_strobes(254);
        step(1);
        chk("ramp_top", {23'b0, dut.level}, 32'd256);
        wait_strobe();
        step(1);
        chk("ramp_hold", {23'b0, dut.level}, 32'd256);
        chk("idle_pcm", {16'b0, dut.pcm_u}, 32'h8000);
        chk("idle_noclip", clip_seen - c0, 32'd0);
        o0 = ones_seen;
        step(1024);
        chk("idle_ones", ones_seen - o0, 32'd512);

        // Positive overflow clamps and flags clip two cycles after the strobe.
        bus.opl_snd = 16'h4000;
        wait_strobe();
        chk("clip_t0", {31'b0, bus.clip}, 32'd0);
        step(1);
        chk("clip_t1", {31'b0, bus.clip}, 32'd0);
        step(1);
        chk("clip_t2", {31'b0, bus.clip}, 32'd1);
        step(1);
        chk("clip_t3", {31'b0, bus.clip}, 32'd0);
        chk("sat_pcm", {16'b0, dut.pcm_u}, 32'hFFFF);
        c0 = clip_seen;
        step(4 * DIV);
        chk("clip_rate", clip_seen - c0, 32'd4);
        o0 = ones_seen;
        step(1024);
        chk("sat_ones", {31'b0, (ones_seen - o0) >= 1023}, 32'd1);

        // Negative in-range sample.
        bus.opl_snd = 16'hE000;
        wait_strobe();
        step(6);
        chk("neg_pcm", {16'b0, dut.pcm_u}, 32'h4000);
        c0 = clip_seen;
        o0 = ones_seen;
        step(1024);
        chk("neg_ones", ones_seen - o0, 32'd256);
        chk("neg_noclip", clip_seen - c0, 32'd0);

        // Speaker only; a glitch between strobes must not reach the output.
        bus.opl_snd    = 16'h0000;
        bus.speaker_in = 1'b1;
        wait_strobe();
        step(6);
        chk("spk_pcm", {16'b0, dut.pcm_u}, 32'hA000);
        o0 = ones_seen;
        step(1024);
        chk("spk_ones", ones_seen - o0, 32'd640);
        wait_strobe();
        step(2);
        bus.speaker_in = 1'b0;
        step(4);
        bus.speaker_in = 1'b1;
        wait_strobe();
        step(4);
        chk("spk_glitch", {16'b0, dut.pcm_u}, 32'hA000);

        // Mute ramp down to silence, hold at zero, then back up.
        bus.speaker_in = 1'b0;
        bus.opl_snd    = 16'h2000;
        wait_strobe();
        step(4);
        chk("mute_start", {16'b0, dut.pcm_u}, 32'hC000);
        bus.mute = 1'b1;
        wait_strobe();
        step(4);
        chk("mute_255", {16'b0, dut.pcm_u}, 32'hBFC0);
        wait_strobes(127);
        step(4);
        chk("mute_128", {16'b0, dut.pcm_u}, 32'hA000);
        wait_strobes(128);
        step(4);
        chk("mute_0", {16'b0, dut.pcm_u}, 32'h8000);
        chk("mute_lvl0", {23'b0, dut.level}, 32'd0);
        wait_strobe();
        step(4);
        chk("mute_hold", {23'b0, dut.level}, 32'd0);
        chk("mute_hold_pcm", {16'b0, dut.pcm_u}, 32'h8000);
        bus.mute = 1'b0;
        wait_strobes(256);
        step(4);
        chk("unmute_pcm", {16'b0, dut.pcm_u}, 32'hC000);
        chk("unmute_lvl", {23'b0, dut.level}, 32'd256);

        // Asynchronous reset while the pin is high.
        wait_strobe();
        step(5);
        n = 0;
        while (bus.aud_l !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        chk("pre_rst_aud", {31'b0, bus.aud_l}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_aud_l",  {31'b0, bus.aud_l}, 32'd0);
        chk("arst_aud_r",  {31'b0, bus.aud_r}, 32'd0);
        chk("arst_clip",   {31'b0, bus.clip}, 32'd0);
        chk("arst_strobe", {31'b0, bus.sample_strobe}, 32'd0);
        step(2);
        chk("arst_pcm",   {16'b0, dut.pcm_u}, 32'h8000);
        chk("arst_level", {23'b0, dut.level}, 32'd0);
        reset = 1'b0;
        first = 0;
        for (int i = 1; i <= 3 * DIV; i++) begin
            step(1);
            if (first == 0 && bus.sample_strobe === 1'b1) first = i;
        end
        chk("rerel_strobe", first, 32'd15);
        chk("rerel_level", {23'b0, dut.level}, 32'd3);

        chk("aud_r_eq_l", ar_diff, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
